// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection and bubble insertion on stall or flush.
module id_ex_stage (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        D_valid,
  input  logic [31:0] D_qa,
  input  logic [31:0] D_qb,
  input  logic [31:0] D_imm,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [4:0]  D_rn,
  input  logic        D_rt_used,
  input  logic [1:0]  D_aluc,
  input  logic        D_aluimm,
  input  logic        D_wreg,
  input  logic        D_m2reg,
  input  logic        D_wmem,
  input  logic        Flush,
  input  logic [4:0]  M_rn,
  input  logic        M_wreg,
  input  logic [31:0] M_r,
  input  logic [4:0]  W_rn,
  input  logic        W_wreg,
  input  logic [31:0] W_d,
  output logic [31:0] X,
  output logic [31:0] Y,
  output logic [1:0]  Aluc,
  output logic [31:0] E_qb,
  output logic [4:0]  E_rn,
  output logic        E_wreg,
  output logic        E_m2reg,
  output logic        E_wmem,
  output logic        E_valid,
  output logic        Stall
);

  logic [31:0] qa, qb, imm;
  logic [4:0]  rs, rt, rn;
  logic [1:0]  aluc;
  logic        aluimm, wreg, m2reg, wmem, valid;
  logic [31:0] fa, fb;
  logic        bubble;

  // A load in EX whose destination is read by the instruction in ID must hold ID one cycle.
  assign Stall = D_valid & valid & m2reg & wreg & (rn != 5'd0) &
                 ((D_rs == rn) | (D_rt_used & (D_rt == rn)));

  assign bubble = Flush | Stall | ~D_valid;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      qa     <= '0;
      qb     <= '0;
      imm    <= '0;
      rs     <= '0;
      rt     <= '0;
      rn     <= '0;
      aluc   <= '0;
      aluimm <= 1'b0;
      wreg   <= 1'b0;
      m2reg  <= 1'b0;
      wmem   <= 1'b0;
      valid  <= 1'b0;
    end else if (bubble) begin
      qa     <= '0;
      qb     <= '0;
      imm    <= '0;
      rs     <= '0;
      rt     <= '0;
      rn     <= '0;
      aluc   <= '0;
      aluimm <= 1'b0;
      wreg   <= 1'b0;
      m2reg  <= 1'b0;
      wmem   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      qa     <= D_qa;
      qb     <= D_qb;
      imm    <= D_imm;
      rs     <= D_rs;
      rt     <= D_rt;
      rn     <= D_rn;
      aluc   <= D_aluc;
      aluimm <= D_aluimm;
      wreg   <= D_wreg;
      m2reg  <= D_m2reg;
      wmem   <= D_wmem;
      valid  <= 1'b1;
    end
  end

  // The younger EX/MEM result takes priority over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fa = qa;
    if (M_wreg && (M_rn != 5'd0) && (M_rn == rs))
      fa = M_r;
    else if (W_wreg && (W_rn != 5'd0) && (W_rn == rs))
      fa = W_d;
  end

  always_comb begin
    fb = qb;
    if (M_wreg && (M_rn != 5'd0) && (M_rn == rt))
      fb = M_r;
    else if (W_wreg && (W_rn != 5'd0) && (W_rn == rt))
      fb = W_d;
  end

  assign X       = fa;
  assign Y       = aluimm ? imm : fb;
  assign E_qb    = fb;
  assign Aluc    = aluc;
  assign E_rn    = rn;
  assign E_wreg  = wreg;
  assign E_m2reg = m2reg;
  assign E_wmem  = wmem;
  assign E_valid = valid;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU in the pipelined core. It latches decoded operands and control from the decode stage each cycle and drives the ALU's `X`, `Y` and `Aluc` inputs. On the way it resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It detects load-use hazards, asserts `Stall` back to IF/ID, and inserts a one-cycle bubble; it also squashes on `Flush`.

## Interface
Parameters: none (data 32 b, register index 5 b, `Aluc` 2 b fixed).

Clock and reset: one clock; reset is asynchronous and active-low.

- `Clk` in 1: rising-edge clock.
- `Clrn` in 1: asynchronous, active-low reset.
- `D_valid` in 1: decode stage holds a real instruction.
- `D_qa`, `D_qb` in 32: register-file read data for rs and rt.
- `D_imm` in 32: extended immediate.
- `D_rs`, `D_rt` in 5: source register indices.
- `D_rn` in 5: destination register index.
- `D_rt_used` in 1: the instruction reads rt (R-type or store).
- `D_aluc` in 2: ALU op (00 add, 01 sub, 10 and, 11 or).
- `D_aluimm` in 1: Y takes the immediate.
- `D_wreg`, `D_m2reg`, `D_wmem` in 1: writes reg, is load, writes memory.
- `Flush` in 1: squash the instruction entering EX (taken branch/jump).
- `M_rn` in 5, `M_wreg` in 1, `M_r` in 32: EX/MEM destination, write enable, ALU result.
- `W_rn` in 5, `W_wreg` in 1, `W_d` in 32: MEM/WB destination, write enable, write-back data.
- `X`, `Y` out 32: ALU operands.
- `Aluc` out 2: ALU op.
- `E_qb` out 32: forwarded rt value (store data).
- `E_rn` out 5; `E_wreg`, `E_m2reg`, `E_wmem`, `E_valid` out 1: EX-stage control, passed downstream.
- `Stall` out 1: hold PC and IF/ID this cycle.

## Operation
- Registered state: `qa`, `qb`, `imm`, `rs`, `rt`, `rn`, `aluc`, `aluimm`, `wreg`, `m2reg`, `wmem`, `valid`.
- **Load-use stall.** `Stall` is combinational:
  - Condition: `D_valid & E_valid & E_m2reg & E_wreg & (E_rn != 0) & (D_rs == E_rn | (D_rt_used & D_rt == E_rn))`.
  - Meaning: the consumer waits in ID while a bubble enters EX.
- **Update each rising edge, in priority order:**
  1. `Flush` or `Stall` or `!D_valid`: latch a bubble. All state registers are cleared to 0.
  2. Otherwise: latch all `D_*` fields and set `valid=1`.
- **Forwarding.** Combinational, applied to the registered `rs` and `rt`:
  - Source `fa`:
    - `M_r` if `M_wreg & M_rn != 0 & M_rn == rs`;
    - else `W_d` if `W_wreg & W_rn != 0 & W_rn == rs`;
    - else `qa`.
  - `fb`: same rule using `rt` and `qb`.
  - EX/MEM always wins over MEM/WB.
  - Register 0 is never forwarded.
- **Outputs:**
  - `X = fa`.
  - `Y = aluimm ? imm : fb`.
  - `E_qb = fb`.
  - `Aluc = aluc`.
  - `E_rn`, `E_wreg`, `E_m2reg`, `E_wmem`, `E_valid` are direct register outputs.
- **Loads.** A load's data never appears on `M_r` for forwarding. The one-cycle stall guarantees that the consumer reaches EX while the load is in WB, so the value comes from `W_d`.

## Timing
- **Reset** (`Clrn`=0, asynchronous): all registers go to 0.
  - Therefore `X=Y=E_qb=0`, `Aluc=00`, `E_rn=0`, `E_wreg=E_m2reg=E_wmem=E_valid=0`, `Stall=0`.
  - Reset released mid-stream: the first edge latches the `D_*` inputs normally.
- **Latency:** decode fields appear on the outputs one cycle after the edge that accepts them. Forwarding paths and `Stall` are zero-latency combinational.
- **Stall length:** exactly 1 cycle per load-use hazard. The bubble clears `E_m2reg`, so `Stall` deasserts on the following cycle.
- **Flush with Stall:** bubble. `Stall` remains asserted that cycle; the upstream stage handles the flush.
- **Both forward sources match:** the EX/MEM value is used.
- **Load then consumer with `rn=0`:** no stall and no forward; the consumer reads `D_qa`/`D_qb` as latched.

## Test plan
- **Reset and basic latch.**
  - Stimulus: hold `Clrn`=0, assert random inputs → all outputs are 0. Release; one edge with `D_valid=1`, `D_qa=5`, `D_qb=7`, `D_aluc=00`, `D_aluimm=0`, no matching M/W writes.
  - Required: `X=5`, `Y=7`, `Aluc=00`, `E_valid=1`.
- **EX/MEM forward with priority.**
  - Stimulus: latched `rs=3`, `rt=4`; `M_rn=3`, `M_wreg=1`, `M_r=0x100`; `W_rn=3`, `W_wreg=1`, `W_d=0x200`; `W_rn` also driven to 4 on a second check.
  - Required: `X=0x100` (M wins). With `W_rn=4`: `Y=W_d` when `aluimm=0`; `Y=imm` when `aluimm=1`, while `E_qb` still equals `W_d`.
- **Register 0 never forwarded.**
  - Stimulus: `rs=0`, `qa=0`, `M_rn=0`, `M_wreg=1`, `M_r=0xFFFF_FFFF`.
  - Required: `X=0`.
- **Load-use stall.**
  - Stimulus: EX holds a load with `E_rn=8`; ID holds an instruction with `D_rs=8`.
  - Required:
    - `Stall=1`; the next edge yields `E_valid=0`, `E_wreg=0`.
    - Next cycle `Stall=0`; the consumer latches, and with `W_rn=8`, `W_d=0x55` gives `X=0x55`.
  - Repeat with `D_rt=8`, `D_rt_used=0` → `Stall=0`.
- **Flush.**
  - Stimulus: `Flush=1` with a valid D instruction having `D_wreg=1`, `D_wmem=1`.
  - Required: after the edge, `E_valid=E_wreg=E_wmem=0`.
- **Asynchronous reset mid-stall.**
  - Stimulus: while `Stall=1`, drop `Clrn` between edges.
  - Required: all outputs go to 0 immediately (no clock) and `Stall=0`.
